// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register.
// Imported by pipe_skid_reg and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_BUSY  = 2'b01,
    PS_FULL  = 2'b10
  } pipe_state_t;

  localparam int DEFAULT_PIPE_W = 64;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter, cleared only by reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with one-entry skid buffer and flush.
// Define PIPE_SKID_STALL_CNT_EN to add the stall_cnt output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_PIPE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Handshake flags are registered alongside the state so that
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= PS_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= PS_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        PS_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= data_in;
            r_state     <= PS_BUSY;
            r_out_valid <= 1'b1;
          end
        end
        PS_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= data_in;
          end else if (w_in_xfer) begin
            r_skid     <= data_in;
            r_state    <= PS_FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state     <= PS_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        PS_FULL: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= PS_BUSY;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= PS_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_main;

`ifdef PIPE_SKID_STALL_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_out_valid && !out_ready),
    .cnt   (stall_cnt)
  );
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue model.
// Stall counter checks run when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;
  localparam int W      = 64;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  logic [W-1:0] m_q[$];
  int           m_cnt;
  int           n_checks;
  int           n_errors;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH     (W),
    .RESET_VAL ('0),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Model: stage is a FIFO of depth 2.
  task automatic tick();
    bit in_x, out_x, stall;
    in_x  = in_valid && (m_q.size() < 2);
    out_x = (m_q.size() > 0) && out_ready;
    stall = (m_q.size() > 0) && !out_ready;
    @(posedge clk);
    if (!reset) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (stall && m_cnt < CNTMAX) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (out_x) void'(m_q.pop_front());
        if (in_x) m_q.push_back(data_in);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    in_valid = 1'b1; data_in = 64'h1234; out_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0) begin
      n_errors++;
      $display("FAIL reset: ov=%b ir=%b d=%h want 0 1 0",
               out_valid, in_ready, data_out);
    end
  endtask

  task automatic test_first_transfer();
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_valid: ov=%b want 0", out_valid);
      end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== 64'h1234) begin
      n_errors++;
      $display("FAIL first_xfer: ov=%b d=%h want 1 1234",
               out_valid, data_out);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [W-1:0] vals[2];
    vals[0] = 64'd4564; vals[1] = 64'd123485;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; data_in = vals[i];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== vals[i] || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream%0d: ov=%b ir=%b d=%0d want 1 1 %0d",
                 i, out_valid, in_ready, data_out, vals[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 64'hA;
    tick();
    data_in = 64'hB;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || data_out !== 64'hA || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: ir=%b ov=%b d=%h want 0 1 a",
               in_ready, out_valid, data_out);
    end
    tick();
    n_checks++;
    if (data_out !== 64'hA || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_hold: ir=%b d=%h want 0 a", in_ready, data_out);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (data_out !== 64'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_drain1: ov=%b ir=%b d=%h want 1 1 b",
               out_valid, in_ready, data_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain2: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 64'h11; tick();
    data_in = 64'h22; tick();
    flush = 1'b1; data_in = 64'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    repeat (3) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_leak: ov=%b d=%h want 0", out_valid, data_out);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 64'h55; tick();
    data_in = 64'h66; tick();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    m_q.delete(); m_cnt = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0) begin
      n_errors++;
      $display("FAIL async_reset: ov=%b ir=%b d=%h want 0 1 0",
               out_valid, in_ready, data_out);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      data_in   = {$urandom, $urandom};
      tick();
      n_checks++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) ||
          (m_q.size() > 0 && data_out !== m_q[0])) begin
        n_errors++;
        $display("FAIL random%0d: ov=%b ir=%b d=%h want n=%0d head=%h",
                 i, out_valid, in_ready, data_out, m_q.size(),
                 (m_q.size() > 0) ? m_q[0] : '0);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

`ifdef PIPE_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    reset = 1'b0; tick(); reset = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; data_in = 64'h77;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (stall_cnt !== 4'd15 || m_cnt != 15) begin
      n_errors++;
      $display("FAIL stall_sat: cnt=%0d want 15", stall_cnt);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_errors++;
      $display("FAIL stall_flush: cnt=%0d want 15", stall_cnt);
    end
    reset = 1'b0; tick();
    n_checks++;
    if (stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL stall_reset: cnt=%0d want 0", stall_cnt);
    end
    reset = 1'b1; out_ready = 1'b1; tick();
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0; m_cnt = 0;
    test_reset();
    test_first_transfer();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PIPE_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
